// File: rtl/parity_gen_tx_if.sv
// -----------------------------------------------------------------------------
// parity_gen_tx_if
//   Bundle of the word-side and serial-side handshakes of parity_gen_tx.
//
//   Signals
//     in_valid  producer offers in_data
//     in_ready  transmitter accepts in_data this cycle
//     in_data   parallel word, DATA_W bits
//     out_valid out_bit is valid
//     out_ready consumer takes out_bit
//     out_bit   serial data/parity bit
//     out_last  high with the parity bit (final bit of a frame)
//     busy      frame in progress
//
//   Modports
//     master  producer/consumer side (drives in_*, out_ready)
//     slave   transmitter side (parity_gen_tx)
// -----------------------------------------------------------------------------
interface parity_gen_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_bit;
    logic              out_last;
    logic              busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bit,
        input  out_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bit,
        output out_last,
        output busy
    );
endinterface

// File: rtl/parity_gen_tx.sv
// -----------------------------------------------------------------------------
// parity_gen_tx
//   Accepts parallel words over a valid/ready handshake and emits each one
//   serially LSB-first followed by a parity bit, giving frames of DATA_W+1 bits.
//   The parity bit is computed once when the word is loaded.
//
//   Parameters
//     DATA_W   data bits per frame, legal range 1..32
//
//   Ports
//     clk      single clock, rising edge
//     rst      synchronous, active-high reset
//     bus      parity_gen_tx_if.slave: in_valid/in_ready/in_data word input,
//              out_valid/out_ready/out_bit/out_last serial output, busy status
//
//   Build option
//     PAR_GEN_ODD_EN  defined: odd parity (frame ones count odd)
//                     undefined (default): even parity
// -----------------------------------------------------------------------------
module parity_gen_tx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    parity_gen_tx_if.slave bus
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StPar
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              par_q, par_d;

    logic in_ready;
    logic out_valid;
    logic out_bit;
    logic out_last;
    logic par_load;

`ifdef PAR_GEN_ODD_EN
    assign par_load = ~^bus.in_data;
`else
    assign par_load = ^bus.in_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    shift_d = bus.in_data;
                    cnt_d   = '0;
                    par_d   = par_load;
                    state_d = StShift;
                end
            end

            StShift: begin
                out_valid = 1'b1;
                out_bit   = shift_q[0];
                // Without out_ready nothing moves, so the current bit is held.
                if (bus.out_ready) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = StPar;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            StPar: begin
                out_valid = 1'b1;
                out_bit   = par_q;
                out_last  = 1'b1;
                // Accept the next word on the edge the parity bit is taken so
                // frames can run back-to-back with no idle bit between them.
                in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        shift_d = bus.in_data;
                        cnt_d   = '0;
                        par_d   = par_load;
                        state_d = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_bit   = out_bit;
    assign bus.out_last  = out_last;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_parity_gen_tx.sv
// -----------------------------------------------------------------------------
// tb_parity_gen_tx
//   Bench for parity_gen_tx. A reference model holds the bits still owed to the
//   serial link as a queue: each accepted word appends its data bits LSB-first
//   and its parity bit. Every cycle the DUT outputs are compared with what that
//   queue implies; directed frames are also compared with constant bit patterns.
// -----------------------------------------------------------------------------
module tb_parity_gen_tx;

    localparam int unsigned DATA_W = 8;

    logic clk;
    logic rst;

    parity_gen_tx_if #(.DATA_W(DATA_W)) bus ();

    parity_gen_tx #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit exp_q[$];   // bits still owed to the link, front = next bit
    bit got[$];     // bits actually taken from the link
    bit mon_en = 1'b0;
    int n_pend;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [DATA_W-1:0] d);
        bit p;
        for (int i = 0; i < int'(DATA_W); i++) exp_q.push_back(d[i]);
        p = ($countones(d) % 2) == 1;
`ifdef PAR_GEN_ODD_EN
        p = !p;
`endif
        exp_q.push_back(p);
    endfunction

    // Per-cycle comparison against the model, then bookkeeping of the
    // handshakes that complete on the coming rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            n_pend = exp_q.size();
            check_eq("out_valid", 32'(bus.out_valid), 32'(n_pend != 0));
            check_eq("busy", 32'(bus.busy), 32'(n_pend != 0));
            check_eq("in_ready", 32'(bus.in_ready),
                     32'((n_pend == 0) || (n_pend == 1 && bus.out_ready)));
            check_eq("out_last", 32'(bus.out_last), 32'(n_pend == 1));
            check_eq("out_bit", 32'(bus.out_bit), 32'((n_pend != 0) ? exp_q[0] : 1'b0));
            if (rst) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    got.push_back(bus.out_bit);
                    if (n_pend != 0) void'(exp_q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) push_frame(bus.in_data);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [DATA_W-1:0] d);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check_eq("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_bits(input int n, output logic [31:0] v);
        for (int c = 0; c < 300 && got.size() < n; c++) begin
            @(posedge clk);
            #1;
        end
        v = '0;
        for (int i = 0; i < n && i < got.size(); i++) v[i] = got[i];
        check_eq("bit_count", 32'(got.size()), 32'(n));
    endtask

    logic [31:0] v;
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          run, acc_n, sent;
    bit          done, accepted;

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 8'hA5 with out_ready high: 1,0,1,0,0,1,0,1 then parity 0
        bus.out_ready = 1'b1;
        got.delete();
        send_word(8'hA5);
        wait_bits(9, v);
        check_eq("frame_a5", v, 32'h0A5);

        // 8'h07: three ones
        got.delete();
        send_word(8'h07);
        wait_bits(9, v);
`ifdef PAR_GEN_ODD_EN
        check_eq("frame_07", v, 32'h007);
`else
        check_eq("frame_07", v, 32'h107);
`endif

        // 8'h3C with out_ready stalled mid-frame
        repeat (2) @(posedge clk);
        #1;
        got.delete();
        send_word(8'h3C);
        for (int i = 0; i < 4; i++) begin
            bus.out_ready = pat[i];
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        wait_bits(9, v);
        check_eq("frame_3c_stall", v, 32'h03C);

        // 8'hFF then 8'h01 back-to-back
        repeat (2) @(posedge clk);
        #1;
        got.delete();
        run   = 0;
        acc_n = 0;
        done  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc_n++;
            if (bus.out_valid) run++;
            else if (run > 0) done = 1'b1;
            @(posedge clk);
            #1;
            if (acc_n == 1) bus.in_data = 8'h01;
            else if (acc_n >= 2) bus.in_valid = 1'b0;
        end
        check_eq("b2b_valid_run", 32'(run), 32'd18);
        wait_bits(18, v);
`ifdef PAR_GEN_ODD_EN
        check_eq("b2b_frames", v, 32'({9'h001, 9'h1FF}));
`else
        check_eq("b2b_frames", v, 32'({9'h101, 9'h0FF}));
`endif

        // Reset after the 3rd bit of a frame
        got.delete();
        send_word(8'h96);
        for (int c = 0; c < 50 && got.size() < 3; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_rst_bits", 32'(got.size()), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        got.delete();
        send_word(8'hC3);
        wait_bits(9, v);
`ifdef PAR_GEN_ODD_EN
        check_eq("post_rst_frame", v, 32'h1C3);
`else
        check_eq("post_rst_frame", v, 32'h0C3);
`endif

        // Randomized traffic with random backpressure
        sent = 0;
        for (int c = 0; c < 8000 && sent < 150; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = DATA_W'($urandom);
            end
            @(negedge clk);
            accepted = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (accepted) begin
                bus.in_valid = 1'b0;
                sent++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("random_frames", 32'(sent), 32'd150);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
